// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the pad configuration chain transmitter.
// Holds the FSM state encoding, pad config field layout and chain-length helper.
package pad_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Field layout of the default 8-bit pad configuration word
  localparam int DRV_LSB     = 0;
  localparam int DRV_W       = 2;
  localparam int PULL_LSB    = 2;
  localparam int PULL_W      = 2;
  localparam int ANA_EN_BIT  = 4;
  localparam int TAP_SEL_LSB = 5;
  localparam int TAP_SEL_W   = 3;

  function automatic int total_bits(input int num_pads, input int cfg_w);
    return num_pads * cfg_w;
  endfunction

endpackage

// File: rtl/pad_cfg_clkgen.sv
// Shift-clock divider: ser_clk_o low for CLK_DIV cycles then high for CLK_DIV.
// rise_o/period_end_o flag the cycle whose closing edge raises ser_clk / starts a new bit.
module pad_cfg_clkgen
  import pad_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic ser_clk_o,
  output logic rise_o,
  output logic period_end_o
);

  localparam int PER = 2 * CLK_DIV;
  localparam int DW  = $clog2(PER);
  localparam logic [DW-1:0] LAST = DW'(PER - 1);
  localparam logic [DW-1:0] RISE = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HIGH = DW'(CLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          clk_q, clk_d;

  // Disabled means parked at the start of a low phase
  always_comb begin
    div_d = '0;
    clk_d = 1'b0;
    if (en_i) begin
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
      clk_d = (div_d >= HIGH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      clk_q <= clk_d;
    end
  end

  assign ser_clk_o    = clk_q;
  assign rise_o       = en_i && (div_q == RISE);
  assign period_end_o = en_i && (div_q == LAST);

endmodule

// File: rtl/pad_cfg_tx.sv
// Pad-ring configuration chain transmitter: shadow image, serial shift, latch strobe
// and capture of the chain's returning bitstream for readback.
module pad_cfg_tx
  import pad_cfg_pkg::*;
#(
  parameter int NUM_PADS = 16,
  parameter int CFG_W    = 8,
  parameter int CLK_DIV  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en_i,
  input  logic [$clog2(NUM_PADS)-1:0] wr_idx_i,
  input  logic [CFG_W-1:0]            wr_data_i,
  input  logic [$clog2(NUM_PADS)-1:0] rd_idx_i,
  output logic [CFG_W-1:0]            rd_data_o,
  input  logic                        start_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        ser_clk_o,
  output logic                        ser_do_o,
  input  logic                        ser_di_i,
  output logic                        ser_latch_o
);

  localparam int IW  = $clog2(NUM_PADS);
  localparam int N   = total_bits(NUM_PADS, CFG_W);
  localparam int BW  = $clog2(N + 1);
  localparam int XW  = $clog2(N);
  localparam int PER = 2 * CLK_DIV;
  localparam int LW  = $clog2(PER);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(PER - 1);
  localparam logic [IW-1:0] TOP_PAD  = IW'(NUM_PADS - 1);

  state_e           state_q;
  logic [BW-1:0]    bit_cnt_q, nxt_cnt;
  logic [LW-1:0]    lat_cnt_q;
  logic             busy_q, done_q, err_q, ser_do_q, latch_q;
  logic [CFG_W-1:0] shadow_q [NUM_PADS];
  logic [CFG_W-1:0] rb_word [NUM_PADS];
  logic [N-1:0]     shadow_flat, rb_q;
  logic             wr_ok, wr_err, start_acc, shift_run, period_end, rise, first_bit;
  logic [XW-1:0]    tx_idx, cap_idx;

  assign wr_ok     = wr_en_i && (state_q == IDLE) && (int'(wr_idx_i) < NUM_PADS);
  assign wr_err    = wr_en_i && !wr_ok;
  assign start_acc = start_i && (state_q == IDLE);
  assign shift_run = (state_q == SHIFT) && !abort_i;

  // Stream bit j maps to flat position N-1-j: pad NUM_PADS-1 MSB first, pad 0 LSB last
  assign nxt_cnt = bit_cnt_q + 1'b1;
  assign tx_idx  = XW'(LAST_BIT - nxt_cnt);
  assign cap_idx = XW'(LAST_BIT - bit_cnt_q);

  // A write landing in the same cycle as start must already be visible in the first bit
  assign first_bit = (wr_ok && wr_idx_i == TOP_PAD) ? wr_data_i[CFG_W-1]
                                                   : shadow_q[NUM_PADS-1][CFG_W-1];

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    assign shadow_flat[gi*CFG_W +: CFG_W] = shadow_q[gi];
    assign rb_word[gi]                    = rb_q[gi*CFG_W +: CFG_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PADS; i++) shadow_q[i] <= '0;
    end else if (wr_ok) begin
      shadow_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rb_q <= '0;
    else if (rise) rb_q[cap_idx] <= ser_di_i;
  end

  pad_cfg_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (shift_run),
    .ser_clk_o    (ser_clk_o),
    .rise_o       (rise),
    .period_end_o (period_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      lat_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ser_do_q  <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_err) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            ser_do_q  <= first_bit;
            err_q     <= wr_err;
          end
        end
        SHIFT: begin
          if (abort_i) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            ser_do_q <= 1'b0;
            err_q    <= 1'b1;
          end else if (period_end) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= LATCH;
              ser_do_q  <= 1'b0;
              latch_q   <= 1'b1;
              lat_cnt_q <= '0;
            end else begin
              bit_cnt_q <= nxt_cnt;
              ser_do_q  <= shadow_flat[tx_idx];
            end
          end
        end
        LATCH: begin
          if (lat_cnt_q == LAST_LAT) begin
            state_q <= IDLE;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data_o   = (int'(rd_idx_i) < NUM_PADS) ? rb_word[rd_idx_i] : '0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign ser_do_o    = ser_do_q;
  assign ser_latch_o = latch_q;

endmodule

// File: tb/tb_pad_cfg_tx.sv
// Directed bench for pad_cfg_tx: default instance, CLK_DIV=1 instance and a 12-pad
// instance for out-of-range writes, with a 128-bit chain model on the serial pins.
`timescale 1ns/1ps
module tb_pad_cfg_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0, wr_en_c = 1'b0, start = 1'b0, abort = 1'b0, start_c = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] wr_idx = '0, rd_idx = '0;
  logic [7:0] wr_data = '0;
  logic       ser_di;
  logic       start_a, start_b;

  logic [7:0] rd_data_a, rd_data_b, rd_data_c, rd_data_m;
  logic busy_a, done_a, err_a, ser_clk_a, ser_do_a, latch_a;
  logic busy_b, done_b, err_b, ser_clk_b, ser_do_b, latch_b;
  logic busy_c, done_c, err_c, ser_clk_c, ser_do_c, latch_c;
  logic busy_m, done_m, err_m, ser_clk_m, ser_do_m, latch_m;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  pad_cfg_tx #(.NUM_PADS(16), .CFG_W(8), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data_a), .start_i(start_a), .abort_i(abort),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .ser_clk_o(ser_clk_a),
    .ser_do_o(ser_do_a), .ser_di_i(ser_di), .ser_latch_o(latch_a));

  pad_cfg_tx #(.NUM_PADS(16), .CFG_W(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data_b), .start_i(start_b), .abort_i(abort),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .ser_clk_o(ser_clk_b),
    .ser_do_o(ser_do_b), .ser_di_i(ser_di), .ser_latch_o(latch_b));

  pad_cfg_tx #(.NUM_PADS(12), .CFG_W(8), .CLK_DIV(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en_c), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data_c), .start_i(start_c), .abort_i(abort),
    .busy_o(busy_c), .done_o(done_c), .err_o(err_c), .ser_clk_o(ser_clk_c),
    .ser_do_o(ser_do_c), .ser_di_i(ser_di), .ser_latch_o(latch_c));

  assign rd_data_m = sel ? rd_data_b : rd_data_a;
  assign busy_m    = sel ? busy_b    : busy_a;
  assign done_m    = sel ? done_b    : done_a;
  assign err_m     = sel ? err_b     : err_a;
  assign ser_clk_m = sel ? ser_clk_b : ser_clk_a;
  assign ser_do_m  = sel ? ser_do_b  : ser_do_a;
  assign latch_m   = sel ? latch_b   : latch_a;

  // Chain model: shifts ser_do in on each ser_clk rise (seen one clk later), MSB returns
  logic [127:0] chain = '0, load_val = '0;
  logic         load = 1'b0, sc_prev = 1'b0;
  assign ser_di = chain[127];
  always @(posedge clk) begin
    sc_prev <= ser_clk_m;
    if (load) chain <= load_val;
    else if (ser_clk_m && !sc_prev) chain <= {chain[126:0], ser_do_m};
  end

  int n_chk = 0, n_fail = 0;
  logic [7:0]   sh [16];
  logic [127:0] stream;
  int latch_first, latch_last, latch_cnt, done_cyc, done_cnt, busy_fall, clk_bad, idle_bad;
  logic err_c1;

`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed %0h required %0h", tag, (obs), (exp)); end end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    wr_en = 1'b1; wr_idx = idx[3:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic preload(input logic [7:0] b);
    load_val = {16{b}}; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  function automatic logic [127:0] img();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = sh[k];
    return r;
  endfunction

  // Starts an update on the selected instance and records what the pins do, cycle by cycle
  task automatic run(input int per, input int abort_at, input int wr_at, input logic simul);
    int limit;
    logic exp_clk;
    limit = 128*per + 2*per + 12;
    latch_first = 0; latch_last = 0; latch_cnt = 0; done_cyc = 0; done_cnt = 0;
    busy_fall = 0; clk_bad = 0; stream = '0; err_c1 = 1'bx;
    start = 1'b1;
    if (simul) begin wr_en = 1'b1; wr_idx = 4'd15; wr_data = 8'h80; end
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (c == 1) err_c1 = err_m;
      if (busy_m !== 1'b1 && busy_fall == 0) busy_fall = c;
      if (latch_m === 1'b1) begin
        if (latch_first == 0) latch_first = c;
        latch_last = c; latch_cnt++;
      end
      if (done_m === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c <= 128*per && busy_m === 1'b1) begin
        exp_clk = ((c-1) % per) >= (per/2);
        if (ser_clk_m !== exp_clk) clk_bad++;
        if ((c-1) % per == 0) stream = {stream[126:0], ser_do_m};
      end else if (ser_clk_m !== 1'b0 || ser_do_m !== 1'b0) begin
        clk_bad++;
      end
      if (c == abort_at) abort = 1'b1;
      if (c == wr_at) begin wr_en = 1'b1; wr_idx = 4'd3; wr_data = 8'h5A; end
      tick();
      abort = 1'b0; wr_en = 1'b0;
      if (done_cyc != 0 && c >= done_cyc + 2) break;
    end
  endtask

  initial begin
    // 1: reset and idle
    repeat (3) tick();
    rst_n = 1'b1;
    `CHK("reset_busy", busy_a, 1'b0)
    `CHK("reset_err", err_a, 1'b0)
    `CHK("reset_rd", rd_data_a, 8'h00)
    `CHK("reset_err_c", err_c, 1'b0)
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if ({busy_a, done_a, err_a, latch_a, ser_clk_a, ser_do_a} !== 6'b0) idle_bad++;
      tick();
    end
    `CHK("idle_quiet", idle_bad, 0)

    // 2: full update with chain preloaded 0xA5
    for (int k = 0; k < 16; k++) begin sh[k] = 8'(k * 8'h11); wr(k, sh[k]); end
    preload(8'hA5);
    run(8, 0, 0, 1'b0);
    for (int k = 0; k < 16; k++) `CHK("stream_pad", stream[k*8 +: 8], sh[k])
    `CHK("latch_first", latch_first, 1025)
    `CHK("latch_last", latch_last, 1032)
    `CHK("latch_cnt", latch_cnt, 8)
    `CHK("done_cycle", done_cyc, 1033)
    `CHK("done_count", done_cnt, 1)
    `CHK("busy_fall", busy_fall, 1033)
    `CHK("ser_clk_shape", clk_bad, 0)
    `CHK("chain_image", chain, img())
    for (int k = 0; k < 16; k++) begin
      rd_idx = k[3:0]; #1;
      `CHK("readback_a5", rd_data_a, 8'hA5)
    end

    // 3: second update returns the first image
    run(8, 0, 0, 1'b0);
    `CHK("done_cycle2", done_cyc, 1033)
    for (int k = 0; k < 16; k++) begin
      rd_idx = k[3:0]; #1;
      `CHK("readback_prev", rd_data_a, sh[k])
    end

    // 4: abort at cycle 300
    preload(8'h3C);
    run(8, 300, 0, 1'b0);
    `CHK("abort_busy_fall", busy_fall, 301)
    `CHK("abort_latch", latch_cnt, 0)
    `CHK("abort_done", done_cnt, 0)
    `CHK("abort_err", err_a, 1'b1)
    `CHK("abort_pins", clk_bad, 0)
    for (int k = 12; k < 16; k++) begin
      rd_idx = k[3:0]; #1;
      `CHK("abort_rb_new", rd_data_a, 8'h3C)
    end
    rd_idx = 4'd10; #1;
    `CHK("abort_rb_old", rd_data_a, sh[10])

    // 5: start clears err; write while busy is dropped and flags err
    run(8, 0, 100, 1'b0);
    `CHK("start_clears_err", err_c1, 1'b0)
    `CHK("busy_write_err", err_a, 1'b1)
    `CHK("busy_write_dropped", stream, img())
    `CHK("done_cycle5", done_cyc, 1033)
    wr_en_c = 1'b1; wr_idx = 4'd2; wr_data = 8'h77; tick(); wr_en_c = 1'b0;
    `CHK("c_valid_write", err_c, 1'b0)
    wr_en_c = 1'b1; wr_idx = 4'd13; tick(); wr_en_c = 1'b0;
    `CHK("c_range_err", err_c, 1'b1)
    `CHK("c_rd", rd_data_c, 8'h00)

    // 6: write and start in the same cycle
    sh[15] = 8'h80;
    run(8, 0, 0, 1'b1);
    `CHK("simul_first_bit", stream[127], 1'b1)
    `CHK("simul_image", stream, img())
    `CHK("simul_done", done_cyc, 1033)

    // CLK_DIV=1 variant
    sel = 1'b1;
    for (int k = 0; k < 16; k++) begin sh[k] = 8'(k * 8'h11); wr(k, sh[k]); end
    run(2, 0, 0, 1'b0);
    `CHK("div1_image", stream, img())
    `CHK("div1_latch_first", latch_first, 257)
    `CHK("div1_latch_last", latch_last, 258)
    `CHK("div1_done", done_cyc, 259)
    `CHK("div1_clk_shape", clk_bad, 0)
    sel = 1'b0;

    // Asynchronous reset mid-shift
    rd_idx = 4'd1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    `CHK("pre_reset_busy", busy_a, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    `CHK("async_busy", busy_a, 1'b0)
    `CHK("async_latch", latch_a, 1'b0)
    `CHK("async_rd", rd_data_a, 8'h00)
    tick();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
